// File: rtl/weapon_fire_resolver.sv
`default_nettype none
//==============================================================================
// weapon_fire_resolver - turns the weapon controller's Firing pulse into ammo,
// gun animation, enemy damage/flash, kill counting and respawn. Rev 1.0
// Optional macro INFINITE_AMMO_EN: ammo pinned at MAX_AMMO, reload ignored.
//==============================================================================
module weapon_fire_resolver #(
    parameter int ENEMY_HP      = 3,
    parameter int DAMAGE        = 1,
    parameter int MAX_AMMO      = 8,
    parameter int FRAME_TICKS   = 12_500_000,
    parameter int RESPAWN_TICKS = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] weapon_state,
    input  logic       on_target,
    input  logic       reload,
    output logic       shot_fired,
    output logic [1:0] gun_frame,
    output logic [3:0] ammo,
    output logic [3:0] enemy_health,
    output logic       enemy_alive,
    output logic       hit_flash,
    output logic [7:0] kill_count
);

    localparam int FRAME_W = $clog2(FRAME_TICKS + 1);
    localparam int RESP_W  = $clog2(RESPAWN_TICKS + 1);

    localparam logic [FRAME_W-1:0] FRAME_LAST   = FRAME_W'(FRAME_TICKS - 1);
    localparam logic [RESP_W-1:0]  RESPAWN_LOAD = RESP_W'(RESPAWN_TICKS);
    localparam logic [3:0]         HP_FULL      = 4'(ENEMY_HP);
    localparam logic [3:0]         DMG          = 4'(DAMAGE);
    localparam logic [3:0]         AMMO_FULL    = 4'(MAX_AMMO);

    localparam logic [2:0] WS_LOADED = 3'b001;
    localparam logic [2:0] WS_FIRING = 3'b010;

    localparam logic [1:0] ST_READY  = 2'd0;
    localparam logic [1:0] ST_FLASH  = 2'd1;
    localparam logic [1:0] ST_RECOIL = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [2:0]         prev_state_q;
    logic [3:0]         ammo_q, ammo_d;
    logic [3:0]         health_q, health_d;
    logic               alive_q, alive_d;
    logic               flash_q, flash_d;
    logic [FRAME_W-1:0] flash_cnt_q, flash_cnt_d;
    logic [RESP_W-1:0]  respawn_q, respawn_d;
    logic [7:0]         kills_q, kills_d;
    logic               shot_q;

    logic       fire_evt;
    logic       shot_ok;
    logic       hit;
    logic [3:0] dmg_health;

    // A held Firing state fires once: only the entry cycle counts.
    assign fire_evt   = (weapon_state == WS_FIRING) && (prev_state_q != WS_FIRING);
    assign shot_ok    = fire_evt && (state_q == ST_READY) && (ammo_q != 4'd0);
    assign hit        = shot_ok && on_target && alive_q;
    assign dmg_health = (health_q > DMG) ? (health_q - DMG) : 4'd0;

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            ST_READY: begin
                if (shot_ok) begin
                    state_d     = ST_FLASH;
                    frame_cnt_d = '0;
                end
            end
            ST_FLASH: begin
                if (frame_cnt_q == FRAME_LAST) begin
                    state_d     = ST_RECOIL;
                    frame_cnt_d = '0;
                end else begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end
            ST_RECOIL: begin
                if (frame_cnt_q == FRAME_LAST) begin
                    state_d     = ST_READY;
                    frame_cnt_d = '0;
                end else begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d     = ST_READY;
                frame_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
`ifdef INFINITE_AMMO_EN
        ammo_d = AMMO_FULL;
`else
        ammo_d = ammo_q;
        if (shot_ok) begin
            ammo_d = ammo_q - 4'd1;
        end else if (reload && (state_q == ST_READY) && !fire_evt) begin
            ammo_d = AMMO_FULL;
        end
`endif
    end

    always_comb begin
        health_d    = health_q;
        alive_d     = alive_q;
        kills_d     = kills_q;
        respawn_d   = respawn_q;
        flash_d     = flash_q;
        flash_cnt_d = flash_cnt_q;
        if (hit) begin
            health_d    = dmg_health;
            flash_d     = 1'b1;
            flash_cnt_d = FRAME_LAST;
            if (dmg_health == 4'd0) begin
                alive_d   = 1'b0;
                respawn_d = RESPAWN_LOAD;
                if (kills_q != 8'hFF) begin
                    kills_d = kills_q + 8'd1;
                end
            end
        end else if (flash_q) begin
            if (flash_cnt_q == '0) begin
                flash_d = 1'b0;
            end else begin
                flash_cnt_d = flash_cnt_q - 1'b1;
            end
        end
        // Hits need a live enemy, so the respawn countdown never collides with one.
        if (!alive_q) begin
            if (respawn_q <= RESP_W'(1)) begin
                alive_d   = 1'b1;
                health_d  = HP_FULL;
                respawn_d = '0;
            end else begin
                respawn_d = respawn_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_READY;
            frame_cnt_q  <= '0;
            prev_state_q <= WS_LOADED;
            ammo_q       <= AMMO_FULL;
            health_q     <= HP_FULL;
            alive_q      <= 1'b1;
            flash_q      <= 1'b0;
            flash_cnt_q  <= '0;
            respawn_q    <= '0;
            kills_q      <= 8'd0;
            shot_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            prev_state_q <= weapon_state;
            ammo_q       <= ammo_d;
            health_q     <= health_d;
            alive_q      <= alive_d;
            flash_q      <= flash_d;
            flash_cnt_q  <= flash_cnt_d;
            respawn_q    <= respawn_d;
            kills_q      <= kills_d;
            shot_q       <= shot_ok;
        end
    end

    always_comb begin
        gun_frame = 2'd0;
        if (state_q == ST_FLASH) begin
            gun_frame = 2'd1;
        end else if (state_q == ST_RECOIL) begin
            gun_frame = 2'd2;
`ifndef INFINITE_AMMO_EN
        end else if (ammo_q == 4'd0) begin
            gun_frame = 2'd3;
`endif
        end
    end

    assign shot_fired   = shot_q;
    assign ammo         = ammo_q;
    assign enemy_health = health_q;
    assign enemy_alive  = alive_q;
    assign hit_flash    = flash_q;
    assign kill_count   = kills_q;

endmodule
`default_nettype wire

// File: tb/tb_weapon_fire_resolver.sv
`default_nettype none
//==============================================================================
// tb_weapon_fire_resolver - directed scenarios plus random stimulus against a
// cycle-level behavioural model of the fire resolver. Rev 1.0
//==============================================================================
module tb_weapon_fire_resolver;

    localparam int FT   = 4;
    localparam int RT   = 10;
    localparam int HP   = 3;
    localparam int DMG  = 1;
    localparam int MAXA = 2;

    logic       clk;
    logic       rst_n;
    logic [2:0] ws;
    logic       tgt;
    logic       rld;
    logic       shot_fired;
    logic [1:0] gun_frame;
    logic [3:0] ammo;
    logic [3:0] enemy_health;
    logic       enemy_alive;
    logic       hit_flash;
    logic [7:0] kill_count;

    int n_checks = 0;
    int n_fail   = 0;

    weapon_fire_resolver #(
        .ENEMY_HP     (HP),
        .DAMAGE       (DMG),
        .MAX_AMMO     (MAXA),
        .FRAME_TICKS  (FT),
        .RESPAWN_TICKS(RT)
    ) dut (
        .clk         (clk),
        .rst         (rst_n),
        .weapon_state(ws),
        .on_target   (tgt),
        .reload      (rld),
        .shot_fired  (shot_fired),
        .gun_frame   (gun_frame),
        .ammo        (ammo),
        .enemy_health(enemy_health),
        .enemy_alive (enemy_alive),
        .hit_flash   (hit_flash),
        .kill_count  (kill_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: anim_left counts down the whole 2*FT-cycle animation in one go;
    // flash_left and dead_left are cycles remaining for each effect.
    logic [2:0] m_prev;
    int         m_anim, m_ammo, m_hp, m_flash, m_dead, m_kills;
    logic       m_alive, m_shot;

    logic [20:0] w_dut;
    assign w_dut = {shot_fired, gun_frame, ammo, enemy_health, enemy_alive, hit_flash, kill_count};

    function automatic logic [20:0] exp_vec();
        logic [1:0] fr;
        if (m_anim > FT)      fr = 2'd1;
        else if (m_anim > 0)  fr = 2'd2;
`ifndef INFINITE_AMMO_EN
        else if (m_ammo == 0) fr = 2'd3;
`endif
        else                  fr = 2'd0;
        return {m_shot, fr, 4'(m_ammo), 4'(m_hp), m_alive, (m_flash > 0), 8'(m_kills)};
    endfunction

    task automatic model_reset();
        m_prev = 3'b001; m_anim = 0; m_ammo = MAXA; m_hp = HP; m_flash = 0;
        m_dead = 0; m_kills = 0; m_alive = 1'b1; m_shot = 1'b0;
    endtask

    task automatic tick();
        logic fire, ready, accept, hit, was_alive;
        @(posedge clk);
        fire      = (ws == 3'b010) && (m_prev != 3'b010);
        ready     = (m_anim == 0);
        accept    = fire && ready && (m_ammo != 0);
        hit       = accept && tgt && m_alive;
        was_alive = m_alive;
        m_shot    = accept;
        if (accept) m_anim = 2 * FT;
        else if (m_anim > 0) m_anim--;
`ifdef INFINITE_AMMO_EN
        m_ammo = MAXA;
`else
        if (accept) m_ammo--;
        else if (rld && ready && !fire) m_ammo = MAXA;
`endif
        if (hit) begin
            m_flash = FT;
            m_hp = (m_hp > DMG) ? m_hp - DMG : 0;
            if (m_hp == 0) begin
                m_alive = 1'b0;
                m_dead  = RT;
                if (m_kills < 255) m_kills++;
            end
        end else if (m_flash > 0) begin
            m_flash--;
        end
        if (!was_alive) begin
            if (m_dead <= 1) begin
                m_alive = 1'b1; m_hp = HP; m_dead = 0;
            end else begin
                m_dead--;
            end
        end
        m_prev = ws;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic apply_reset();
        ws = 3'b001; tgt = 1'b0; rld = 1'b0;
        rst_n = 1'b0;
        #2;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic fire_once(input logic on_tgt);
        ws = 3'b010; tgt = on_tgt;
        tick();
        ws = 3'b100; tgt = 1'b0;
    endtask

    task automatic kill_enemy();
        for (int k = 0; k < 3; k++) begin
            fire_once(1'b1);
            if (k < 2) begin
                run(8);
                rld = 1'b1; tick(); rld = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        apply_reset();
        #1;
        n_checks++;
        if (w_dut !== {1'b0, 2'd0, 4'(MAXA), 4'(HP), 1'b1, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_values dut=%h exp=%h", w_dut, {1'b0, 2'd0, 4'(MAXA), 4'(HP), 1'b1, 1'b0, 8'd0});
        end
        tick();
        n_checks++;
        if (w_dut !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_idle dut=%h exp=%h", w_dut, exp_vec());
        end
    endtask

    task automatic test_single_shot();
        int n1, n2, nf, ns;
        apply_reset();
        fire_once(1'b1);
        n_checks++;
        if ({shot_fired, ammo, enemy_health, hit_flash, gun_frame} !== {1'b1, 4'd1, 4'd2, 1'b1, 2'd1}) begin
            n_fail++;
            $display("FAIL first_shot dut=%h exp=%h", {shot_fired, ammo, enemy_health, hit_flash, gun_frame},
                     {1'b1, 4'd1, 4'd2, 1'b1, 2'd1});
        end
        n1 = 1; n2 = 0; nf = 1; ns = 1;
        for (int i = 1; i < 12; i++) begin
            tick();
            n_checks++;
            if (w_dut !== exp_vec()) begin
                n_fail++;
                $display("FAIL shot_anim cyc=%0d dut=%h exp=%h", i, w_dut, exp_vec());
            end
            if (gun_frame == 2'd1) n1++;
            if (gun_frame == 2'd2) n2++;
            if (hit_flash) nf++;
            if (shot_fired) ns++;
        end
        n_checks++;
        if ({n1, n2, nf, ns} !== {32'd4, 32'd4, 32'd4, 32'd1} || gun_frame !== 2'd0) begin
            n_fail++;
            $display("FAIL anim_lengths flash=%0d recoil=%0d hitflash=%0d shots=%0d frame=%0d exp 4/4/4/1/0",
                     n1, n2, nf, ns, gun_frame);
        end
    endtask

    task automatic test_drop_in_flash();
        apply_reset();
        fire_once(1'b0);
        tick();
        ws = 3'b010;
        tick();
        ws = 3'b100;
        n_checks++;
        if ({shot_fired, ammo, gun_frame} !== {1'b0, 4'(MAXA - 1), 2'd1}) begin
            n_fail++;
            $display("FAIL drop_in_flash dut=%h exp=%h", {shot_fired, ammo, gun_frame}, {1'b0, 4'(MAXA - 1), 2'd1});
        end
        run(8);
        n_checks++;
        if (w_dut !== exp_vec()) begin
            n_fail++;
            $display("FAIL drop_recover dut=%h exp=%h", w_dut, exp_vec());
        end
    endtask

    task automatic test_kill_respawn();
        apply_reset();
        kill_enemy();
        n_checks++;
        if ({enemy_health, enemy_alive, kill_count, hit_flash} !== {4'd0, 1'b0, 8'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL kill dut=%h exp=%h", {enemy_health, enemy_alive, kill_count, hit_flash},
                     {4'd0, 1'b0, 8'd1, 1'b1});
        end
        for (int i = 1; i <= RT; i++) begin
            tick();
            n_checks++;
            if (enemy_alive !== (i == RT) || w_dut !== exp_vec()) begin
                n_fail++;
                $display("FAIL respawn cyc=%0d alive=%0b dut=%h exp=%h", i, enemy_alive, w_dut, exp_vec());
            end
        end
        n_checks++;
        if ({enemy_health, enemy_alive} !== {4'(HP), 1'b1}) begin
            n_fail++;
            $display("FAIL respawn_hp dut=%h exp=%h", {enemy_health, enemy_alive}, {4'(HP), 1'b1});
        end
    endtask

    task automatic test_dry_fire();
        apply_reset();
        fire_once(1'b0); run(8);
        fire_once(1'b0); run(8);
        n_checks++;
        if ({ammo, gun_frame} !== {4'd0, 2'd3}) begin
            n_fail++;
            $display("FAIL empty dut=%h exp=%h", {ammo, gun_frame}, {4'd0, 2'd3});
        end
        fire_once(1'b1);
        n_checks++;
        if ({shot_fired, ammo, gun_frame, enemy_health, hit_flash} !== {1'b0, 4'd0, 2'd3, 4'(HP), 1'b0}) begin
            n_fail++;
            $display("FAIL dry_fire dut=%h exp=%h", {shot_fired, ammo, gun_frame, enemy_health, hit_flash},
                     {1'b0, 4'd0, 2'd3, 4'(HP), 1'b0});
        end
        rld = 1'b1; tick(); rld = 1'b0;
        n_checks++;
        if ({ammo, gun_frame} !== {4'(MAXA), 2'd0}) begin
            n_fail++;
            $display("FAIL reload dut=%h exp=%h", {ammo, gun_frame}, {4'(MAXA), 2'd0});
        end
    endtask

    task automatic test_back_to_back();
        int ns;
        apply_reset();
        ws = 3'b010; ns = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (shot_fired) ns++;
        end
        n_checks++;
        if (ns !== 1) begin
            n_fail++;
            $display("FAIL held_firing shots=%0d exp=1", ns);
        end
        ws = 3'b100; run(4);
        ws = 3'b011; tick();
        n_checks++;
        if (shot_fired !== 1'b0 || w_dut !== exp_vec()) begin
            n_fail++;
            $display("FAIL non_onehot dut=%h exp=%h", w_dut, exp_vec());
        end
        ws = 3'b010; rld = 1'b1; tick();
        ws = 3'b100; rld = 1'b0;
        n_checks++;
        if ({shot_fired, ammo} !== {1'b1, 4'(MAXA - 2)}) begin
            n_fail++;
            $display("FAIL shot_beats_reload dut=%h exp=%h", {shot_fired, ammo}, {1'b1, 4'(MAXA - 2)});
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        fire_once(1'b1);
        tick();
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (w_dut !== {1'b0, 2'd0, 4'(MAXA), 4'(HP), 1'b1, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL async_rst_flash dut=%h exp=%h", w_dut, {1'b0, 2'd0, 4'(MAXA), 4'(HP), 1'b1, 1'b0, 8'd0});
        end
        model_reset();
        rst_n = 1'b1;
        kill_enemy();
        run(3);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (w_dut !== {1'b0, 2'd0, 4'(MAXA), 4'(HP), 1'b1, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL async_rst_respawn dut=%h exp=%h", w_dut, {1'b0, 2'd0, 4'(MAXA), 4'(HP), 1'b1, 1'b0, 8'd0});
        end
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int r;
        logic [2:0] junk [4];
        junk[0] = 3'b011; junk[1] = 3'b110; junk[2] = 3'b000; junk[3] = 3'b111;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 20)      ws = 3'b010;
            else if (r < 24) ws = junk[$urandom_range(0, 3)];
            else if (r < 65) ws = 3'b100;
            else             ws = 3'b001;
            tgt = ($urandom_range(0, 3) != 0);
            rld = ($urandom_range(0, 7) == 0);
            tick();
            n_checks++;
            if (w_dut !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc=%0d dut=%h exp=%h", i, w_dut, exp_vec());
            end
        end
        ws = 3'b001; tgt = 1'b0; rld = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ws = 3'b001; tgt = 1'b0; rld = 1'b0;
        model_reset();
        test_reset();
        test_single_shot();
        test_drop_in_flash();
        test_kill_respawn();
        test_dry_fire();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/weapon_fire_resolver.md
Name: weapon_fire_resolver

Overview:
- Consumer end of the weapon controller's `weapon_state` interface.
- Detects the one-cycle Firing state and turns it into game effects: ammo consumption, gun sprite animation frames, enemy damage and hit flash, kill counting and enemy respawn.
- Sits between the weapon controller and the VGA sprite/enemy renderers.

Parameters:
- ENEMY_HP, 3, enemy health after reset and after respawn (1..15).
- DAMAGE, 1, health removed per hit (1..15).
- MAX_AMMO, 8, rounds after reset and after reload (1..15).
- FRAME_TICKS, 12_500_000, clocks per gun animation frame; also the hit-flash length.
- RESPAWN_TICKS, 100_000_000, clocks the enemy stays dead before respawn.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- weapon_state  in  3  one-hot state from the weapon controller: 001 Loaded, 010 Firing, 100 Fire_Idle
- on_target  in  1  crosshair currently overlaps a live enemy (level)
- reload  in  1  reload request (level; sampled each clock)
- shot_fired  out  1  one-cycle pulse per accepted shot
- gun_frame  out  2  0 ready, 1 muzzle flash, 2 recoil, 3 empty (ready with ammo==0)
- ammo  out  4  rounds remaining
- enemy_health  out  4  current enemy health
- enemy_alive  out  1  enemy present
- hit_flash  out  1  enemy damage flash
- kill_count  out  8  kills, saturating at 255

Behaviour:
- Reset (rst=0, async) sets every output and register as follows:
  - ammo=MAX_AMMO, enemy_health=ENEMY_HP, enemy_alive=1.
  - kill_count=0, shot_fired=0, hit_flash=0, gun_frame=0.
  - Animation FSM in READY; all timers 0; prev_state=001.
- Fire event:
  - fire_evt = (weapon_state==010) && (prev_state!=010). prev_state is registered every clock.
  - A held 010 therefore counts once. Non-one-hot values are ignored and leave outputs unchanged.
- Shot acceptance:
  - Accepted only if fire_evt && FSM==READY && ammo!=0.
  - On acceptance, at the next edge: shot_fired=1 for exactly one cycle, ammo decrements by 1, and the FSM goes to FLASH.
  - Latency from the Firing cycle to shot_fired is 1 clock.
- Rejected shots:
  - fire_evt in FLASH or RECOIL is dropped: no ammo change, no pulse.
  - fire_evt with ammo==0 (dry fire): no pulse, no damage, gun_frame stays 3.
- Animation FSM:
  - READY -> FLASH on an accepted shot.
  - FLASH (gun_frame=1) -> RECOIL after FRAME_TICKS clocks.
  - RECOIL (gun_frame=2) -> READY after FRAME_TICKS clocks.
  - In READY, gun_frame = (ammo==0) ? 3 : 0.
- Hit resolution (same edge as acceptance):
  - Applies if on_target && enemy_alive.
  - enemy_health = max(enemy_health - DAMAGE, 0), saturating with no wrap.
  - hit_flash=1 for FRAME_TICKS clocks; a new hit restarts the flash timer.
  - on_target while the enemy is dead is a miss.
- Kill and respawn:
  - When health reaches 0: enemy_alive=0, kill_count+1 (stays at 255 if already 255), respawn timer loads RESPAWN_TICKS.
  - hit_flash still runs its full length.
  - When the timer expires: enemy_health=ENEMY_HP, enemy_alive=1.
- Reload:
  - reload=1 while FSM==READY and no fire_evt this cycle sets ammo=MAX_AMMO at the next edge.
  - Reload during FLASH or RECOIL is ignored.
  - Reload coincident with an accepted shot: the shot wins and ammo decrements.
- Reset mid-animation or mid-respawn aborts immediately to the reset values.

Optional Feature:
- Macro: INFINITE_AMMO_EN.
- Defined:
  - ammo is held at MAX_AMMO and never decrements.
  - reload is ignored.
  - gun_frame never shows 3.
  - All other behaviour is unchanged.
- Undefined: behaviour as described above.

Test Plan:
- Bench parameters for all scenarios: FRAME_TICKS=4, RESPAWN_TICKS=10, ENEMY_HP=3, DAMAGE=1, MAX_AMMO=2.
- Reset, then one Firing cycle with on_target=1 -> next clock: shot_fired=1 for 1 cycle, ammo=1, enemy_health=2, hit_flash=1 for 4 clocks; gun_frame runs 1 for 4 clocks, then 2 for 4 clocks, then 0.
- Firing again 2 clocks after the first accepted shot (FSM in FLASH) -> no shot_fired, ammo unchanged.
- Three accepted on-target shots with reload between -> health 3->2->1->0, enemy_alive=0, kill_count=1; after 10 clocks health=3, enemy_alive=1.
- Two shots empty the gun -> gun_frame=3; a third Firing -> no pulse, ammo=0; then reload=1 in READY -> ammo=2, gun_frame=0.
- weapon_state held 010 for 5 clocks -> exactly one shot_fired; weapon_state=011 -> ignored; reload asserted on an accepted-shot cycle -> ammo decrements, no reload.
- rst=0 asserted mid-FLASH and mid-respawn -> all outputs at reset values asynchronously.
